// File: rtl/starflux_pkg.sv
// Shared constants, colour codes and FSM state type for the starflux renderer.
package starflux_pkg;

    localparam int W      = 160;
    localparam int H      = 120;
    localparam int SHIP_W = 8;
    localparam int SHIP_H = 4;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_SHIP  = 3'b010;
    localparam logic [2:0] COL_ENEMY = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/grid_renderer_if.sv
// Frame request, grid/sprite inputs and pixel-write stream between the
// game control/datapath (slave side) and the renderer (master side).
interface grid_renderer_if;
    import starflux_pkg::*;

    logic             start;
    logic [W*H-1:0]   grid;
    logic [7:0]       user_x;
    logic [7:0]       enemy_x;
    logic [7:0]       x;
    logic [6:0]       y;
    logic [2:0]       colour;
    logic             plot;
    logic             busy;
    logic             done;

    modport master (
        input  start, grid, user_x, enemy_x,
        output x, y, colour, plot, busy, done
    );

    modport slave (
        output start, grid, user_x, enemy_x,
        input  x, y, colour, plot, busy, done
    );

endinterface

// File: rtl/grid_scan_counter.sv
// Raster scan counter: cx runs fastest, cy advances on cx wrap; last flags (W-1, H-1).
module grid_scan_counter #(
    parameter int W = 160,
    parameter int H = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] cx,
    output logic [6:0] cy,
    output logic       last
);

    logic [7:0] cx_reg;
    logic [6:0] cy_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else if (enable) begin
            if (cx_reg == 8'(W - 1)) begin
                cx_reg <= '0;
                cy_reg <= (cy_reg == 7'(H - 1)) ? 7'd0 : cy_reg + 7'd1;
            end else begin
                cx_reg <= cx_reg + 8'd1;
            end
        end
    end

    assign cx   = cx_reg;
    assign cy   = cy_reg;
    assign last = (cx_reg == 8'(W - 1)) && (cy_reg == 7'(H - 1));

endmodule

// File: rtl/grid_renderer.sv
// Scans the bullet grid once per start and emits one classified pixel per cycle.
// Sprite overlays are built only when STARFLUX_SPRITES_EN is defined.
module grid_renderer
    import starflux_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    grid_renderer_if.master  bus
);

    state_t      state_reg;
    logic [7:0]  cx;
    logic [6:0]  cy;
    logic        last;
    logic        clear;
    logic        enable;
    logic [14:0] pixel_idx;
    logic        grid_bit;
    logic [2:0]  colour_next;

    assign clear  = (state_reg == IDLE) && bus.start;
    assign enable = (state_reg == DRAW);

    grid_scan_counter #(.W(W), .H(H)) u_scan (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    assign pixel_idx = 15'(cy) * 15'(W) + 15'(cx);
    assign grid_bit  = bus.grid[pixel_idx];

`ifdef STARFLUX_SPRITES_EN
    // Index 0 is the ship (bottom rows), index 1 the enemy (top rows).
    logic [1:0] sprite_hit;

    for (genvar gi = 0; gi < 2; gi++) begin : g_sprite
        logic [7:0] pos_reg;
        logic [7:0] pos_in;
        logic [8:0] left;
        logic [8:0] right;
        logic       row_hit;

        assign pos_in = (gi == 0) ? bus.user_x : bus.enemy_x;

        always_ff @(posedge clk) begin
            if (reset) begin
                pos_reg <= '0;
            end else if (clear) begin
                pos_reg <= pos_in;
            end
        end

        // 9-bit bounds so a sprite near the right edge clips instead of wrapping.
        assign left  = {1'b0, pos_reg};
        assign right = left + 9'(SHIP_W);

        if (gi == 0) begin : g_ship_rows
            assign row_hit = (cy >= 7'(H - SHIP_H));
        end else begin : g_enemy_rows
            assign row_hit = (cy < 7'(SHIP_H));
        end

        assign sprite_hit[gi] = row_hit && ({1'b0, cx} >= left) && ({1'b0, cx} < right);
    end

    always_comb begin
        colour_next = COL_BLACK;
        if (sprite_hit[0]) begin
            colour_next = COL_SHIP;
        end else if (sprite_hit[1]) begin
            colour_next = COL_ENEMY;
        end else if (grid_bit) begin
            colour_next = COL_WHITE;
        end
    end
`else
    logic unused_sprite_pos;
    assign unused_sprite_pos = ^{bus.user_x, bus.enemy_x};

    always_comb begin
        colour_next = grid_bit ? COL_WHITE : COL_BLACK;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            bus.x      <= '0;
            bus.y      <= '0;
            bus.colour <= COL_BLACK;
            bus.plot   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.plot <= 1'b0;
            bus.done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= DRAW;
                        bus.busy  <= 1'b1;
                    end
                end
                DRAW: begin
                    bus.x      <= cx;
                    bus.y      <= cy;
                    bus.colour <= colour_next;
                    bus.plot   <= 1'b1;
                    if (last) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer: full-frame scans compared pixel by pixel
// against a raster/classification model of the frame.
module tb_grid_renderer;

    localparam int GW     = 160;
    localparam int GH     = 120;
    localparam int SPR_W  = 8;
    localparam int SPR_H  = 4;
    localparam int NPIX   = GW * GH;

    logic clk;
    logic reset;

    grid_renderer_if bus ();

    grid_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int vectors;
    int miscompares;

    logic [NPIX-1:0] m_grid;
    int              m_ux;
    int              m_ex;

    function automatic logic [2:0] exp_colour(input int px, input int py);
`ifdef STARFLUX_SPRITES_EN
        if (py >= GH - SPR_H && px >= m_ux && px < m_ux + SPR_W) return 3'b010;
        if (py < SPR_H && px >= m_ex && px < m_ex + SPR_W) return 3'b100;
`endif
        if (m_grid[py * GW + px]) return 3'b111;
        return 3'b000;
    endfunction

    task automatic random_grid(input int density);
        for (int i = 0; i < NPIX; i++) begin
            m_grid[i] = ($urandom_range(0, density - 1) == 0);
        end
    endtask

    // Pulse start, then scramble the live sprite inputs: the frame must use the latched copies.
    task automatic begin_frame();
        bus.grid    = m_grid;
        bus.user_x  = 8'(m_ux);
        bus.enemy_x = 8'(m_ex);
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.user_x  = 8'($urandom);
        bus.enemy_x = 8'($urandom);
        vectors++;
        if (bus.busy !== 1'b1 || bus.plot !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL start_accept: got busy=%b plot=%b done=%b, want busy=1 plot=0 done=0",
                     bus.busy, bus.plot, bus.done);
        end
    endtask

    task automatic check_pixels(input int first, input int last_c, input int dup_at);
        logic [20:0] act;
        logic [20:0] exp;
        int px;
        int py;
        for (int c = first; c <= last_c; c++) begin
            @(posedge clk); #1;
            px  = (c - 1) % GW;
            py  = (c - 1) / GW;
            exp = {1'b1, 1'b1, 1'b0, 8'(px), 7'(py), exp_colour(px, py)};
            act = {bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL pixel c=%0d: got plot=%b busy=%b done=%b x=%0d y=%0d colour=%b, want plot=1 busy=1 done=0 x=%0d y=%0d colour=%b",
                         c, bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour, px, py, exp[2:0]);
            end
            bus.start = (c == dup_at - 1);
        end
        bus.start = 1'b0;
    endtask

    task automatic check_done();
        @(posedge clk); #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.plot !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got done=%b busy=%b plot=%b, want done=1 busy=0 plot=0",
                     bus.done, bus.busy, bus.plot);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.plot !== 1'b0) begin
                miscompares++;
                $display("FAIL after_done[%0d]: got done=%b busy=%b plot=%b, want 0 0 0",
                         i, bus.done, bus.busy, bus.plot);
            end
        end
    endtask

    task automatic check_idle_zero(input string name);
        vectors++;
        if ({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done} !== 21'd0) begin
            miscompares++;
            $display("FAIL %s: got x=%0d y=%0d colour=%b plot=%b busy=%b done=%b, want all 0",
                     name, bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset_values");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("idle_no_start");
        reset = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.start = 1'b0;
        check_idle_zero("reset_beats_start");
        @(posedge clk); #1;
        check_idle_zero("reset_beats_start_next");
    endtask

    task automatic test_empty_dup_start();
        m_grid = '0;
        m_ux = 20;
        m_ex = 100;
        begin_frame();
        check_pixels(1, NPIX, 500);
        check_done();
    endtask

    task automatic test_bullets_priority();
        random_grid(7);
        m_grid[8010] = 1'b1;
        m_grid[118 * GW + 22] = 1'b1;
        m_ux = 20;
        m_ex = $urandom_range(40, 152);
        begin_frame();
        check_pixels(1, NPIX, 0);
        check_done();
    endtask

    task automatic test_edge_clip();
        random_grid(5);
        m_ux = 156;
        m_ex = $urandom_range(250, 255);
        begin_frame();
        check_pixels(1, NPIX, 0);
        check_done();
    endtask

    task automatic test_reset_midframe();
        random_grid(3);
        m_ux = $urandom_range(0, 255);
        m_ex = $urandom_range(0, 255);
        begin_frame();
        check_pixels(1, 999, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_zero("reset_midframe");
        for (int c = 1001; c <= 1009; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset c=%0d: got plot=%b busy=%b done=%b, want 0 0 0",
                         c, bus.plot, bus.busy, bus.done);
            end
        end
        m_ux = $urandom_range(0, 160);
        m_ex = $urandom_range(0, 160);
        begin_frame();
        check_pixels(1, 40, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_zero("reset_cleanup");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.grid    = '0;
        bus.user_x  = '0;
        bus.enemy_x = '0;
        m_grid      = '0;
        m_ux        = 0;
        m_ex        = 0;
        @(posedge clk); #1;

        test_reset();
        test_empty_dup_start();
        test_bullets_priority();
        test_edge_clip();
        test_reset_midframe();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
